// File: rtl/spi_slave_if.sv
// SPI slave serial front end: deserialises MOSI into 10-bit command words and serialises RAM read data on MISO.
// Define SPI_SLAVE_TX_TIMEOUT_EN to bound the READ_DATA wait for tx_valid to TX_TIMEOUT edges.
module spi_slave_if #(
  parameter int ADDR_SIZE  = 8,
  parameter int TX_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [9:0]           rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
);
  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

  localparam int TXC_W = $clog2(ADDR_SIZE + 1);
  localparam logic [TXC_W-1:0] TX_LAST = TXC_W'(ADDR_SIZE);

  state_t               state_reg, state_next;
  logic [3:0]           bit_cnt_reg, bit_cnt_next;
  logic [9:0]           shift_reg, shift_next;
  logic                 frame_done_reg, frame_done_next;
  logic                 rd_addr_seen_reg, rd_addr_seen_next;
  logic [TXC_W-1:0]     tx_cnt_reg, tx_cnt_next;
  logic [ADDR_SIZE-1:0] tx_shift_reg, tx_shift_next;
  logic                 miso_reg, miso_next;
  logic [9:0]           rx_data_reg, rx_data_next;
  logic                 rx_valid_reg, rx_valid_next;
  logic                 timeout;
  logic                 lockout;

`ifdef SPI_SLAVE_TX_TIMEOUT_EN
  localparam int TOC_W = $clog2(TX_TIMEOUT + 1);
  localparam logic [TOC_W-1:0] TO_LAST = TOC_W'(TX_TIMEOUT - 1);

  logic [TOC_W-1:0] to_cnt_reg, to_cnt_next;
  logic             lockout_reg, lockout_next;
  logic             wait_phase;

  assign wait_phase = (state_reg == READ_DATA) && frame_done_reg && (tx_cnt_reg == '0);
  assign lockout    = lockout_reg;

  // After a timeout the select line must be released before a new frame is accepted.
  always_comb begin
    to_cnt_next  = to_cnt_reg;
    lockout_next = lockout_reg;
    timeout      = 1'b0;
    if (SS_n) begin
      to_cnt_next  = '0;
      lockout_next = 1'b0;
    end else if (wait_phase && !tx_valid) begin
      if (to_cnt_reg == TO_LAST) begin
        timeout      = 1'b1;
        to_cnt_next  = '0;
        lockout_next = 1'b1;
      end else begin
        to_cnt_next = to_cnt_reg + TOC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_reg  <= '0;
      lockout_reg <= 1'b0;
    end else begin
      to_cnt_reg  <= to_cnt_next;
      lockout_reg <= lockout_next;
    end
  end
`else
  assign timeout = 1'b0;
  assign lockout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (SS_n) begin
      state_next = IDLE;
    end else if (timeout) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (!lockout) state_next = CHK_CMD;
        CHK_CMD: state_next = !MOSI ? WRITE : (rd_addr_seen_reg ? READ_DATA : READ_ADD);
        default: state_next = state_reg;
      endcase
    end
  end

  always_comb begin
    bit_cnt_next      = bit_cnt_reg;
    shift_next        = shift_reg;
    frame_done_next   = frame_done_reg;
    rd_addr_seen_next = rd_addr_seen_reg;
    tx_cnt_next       = tx_cnt_reg;
    tx_shift_next     = tx_shift_reg;
    miso_next         = miso_reg;
    rx_data_next      = rx_data_reg;
    rx_valid_next     = 1'b0;
    if (SS_n || state_reg == IDLE) begin
      bit_cnt_next    = '0;
      frame_done_next = 1'b0;
      tx_cnt_next     = '0;
      miso_next       = 1'b0;
    end else if (state_reg == CHK_CMD) begin
      shift_next   = {9'b0, MOSI};
      bit_cnt_next = 4'd1;
    end else if (!frame_done_reg) begin
      shift_next   = {shift_reg[8:0], MOSI};
      bit_cnt_next = bit_cnt_reg + 4'd1;
      if (bit_cnt_reg == 4'd9) begin
        frame_done_next = 1'b1;
        rx_valid_next   = 1'b1;
        rx_data_next    = {shift_reg[8:0], MOSI};
        if (state_reg == READ_ADD)       rd_addr_seen_next = 1'b1;
        else if (state_reg == READ_DATA) rd_addr_seen_next = 1'b0;
      end
    end else if (state_reg == READ_DATA) begin
      // tx_cnt: 0 = waiting for tx_valid, 1..ADDR_SIZE-1 = shifting, ADDR_SIZE = finished
      if (tx_cnt_reg == '0) begin
        if (tx_valid) begin
          miso_next     = tx_data[ADDR_SIZE-1];
          tx_shift_next = tx_data << 1;
          tx_cnt_next   = TXC_W'(1);
        end
      end else if (tx_cnt_reg < TX_LAST) begin
        miso_next     = tx_shift_reg[ADDR_SIZE-1];
        tx_shift_next = tx_shift_reg << 1;
        tx_cnt_next   = tx_cnt_reg + TXC_W'(1);
      end else begin
        miso_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_reg      <= '0;
      shift_reg        <= '0;
      frame_done_reg   <= 1'b0;
      rd_addr_seen_reg <= 1'b0;
      tx_cnt_reg       <= '0;
      tx_shift_reg     <= '0;
      miso_reg         <= 1'b0;
      rx_data_reg      <= '0;
      rx_valid_reg     <= 1'b0;
    end else begin
      bit_cnt_reg      <= bit_cnt_next;
      shift_reg        <= shift_next;
      frame_done_reg   <= frame_done_next;
      rd_addr_seen_reg <= rd_addr_seen_next;
      tx_cnt_reg       <= tx_cnt_next;
      tx_shift_reg     <= tx_shift_next;
      miso_reg         <= miso_next;
      rx_data_reg      <= rx_data_next;
      rx_valid_reg     <= rx_valid_next;
    end
  end

  assign MISO     = miso_reg;
  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;
endmodule

// File: tb/tb_spi_slave_if.sv
// Randomised bench for spi_slave_if against a frame-level model of command decoding and MISO read-back.
// Honours SPI_SLAVE_TX_TIMEOUT_EN when the design is built with it.
module tb_spi_slave_if;
  localparam int ADDR_SIZE  = 8;
  localparam int TX_TIMEOUT = 16;
  localparam int K_WRITE = 0, K_RADD = 1, K_RDATA = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         pulses;
  int         frame_no = 0;
  logic [9:0] last_word;
  bit         seen_model = 1'b0;

  spi_slave_if #(.ADDR_SIZE(ADDR_SIZE), .TX_TIMEOUT(TX_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge: apply inputs, let one rising edge pass, sample at the next falling edge.
  task automatic cycle(input logic ss, input logic mosi, input logic txv, input logic [7:0] txd);
    SS_n = ss; MOSI = mosi; tx_valid = txv; tx_data = txd;
    @(negedge clk);
    if (rx_valid) begin
      pulses++;
      last_word = rx_data;
    end
  endtask

  // nbits < 10 aborts the frame; w = edges after rx_valid before the RAM presents tx_valid.
  task automatic run_frame(input logic [9:0] word, input int nbits, input logic [7:0] rdata, input int w);
    logic [127:0] got_v, exp_v;
    int  kind;
    bit  timed_out;
    pulses = 0;
    got_v = '0;
    exp_v = '0;
    frame_no++;
    cycle(1'b0, 1'($urandom), 1'b0, 8'($urandom));
    for (int i = 9; i > 9 - nbits; i--) cycle(1'b0, word[i], 1'b0, 8'($urandom));
    if (nbits < 10) begin
      cycle(1'b1, 1'($urandom), 1'b0, 8'h00);
      check("abort_no_rx_valid", 128'(pulses), 128'(0));
      check("abort_miso", 128'(MISO), 128'(0));
      $display("frame %0d word=%03h aborted after %0d bits", frame_no, word, nbits);
      return;
    end
    check("rx_valid_timing", 128'(rx_valid), 128'(1));
    check("rx_data", 128'(last_word), 128'(word));
    if (!word[9]) kind = K_WRITE;
    else if (!seen_model) begin kind = K_RADD;  seen_model = 1'b1; end
    else                  begin kind = K_RDATA; seen_model = 1'b0; end
    timed_out = 1'b0;
`ifdef SPI_SLAVE_TX_TIMEOUT_EN
    timed_out = (w >= TX_TIMEOUT);
`endif
    for (int k = 0; k < w + 14; k++) begin
      cycle(1'b0, 1'($urandom), (k == w), (k == w) ? rdata : 8'($urandom));
      got_v[k] = MISO;
      if (kind == K_RDATA && !timed_out && k >= w && k < w + 8) exp_v[k] = rdata[7 - (k - w)];
    end
    check("miso_stream", got_v, exp_v);
    check("rx_valid_pulses", 128'(pulses), 128'(1));
    cycle(1'b1, 1'($urandom), 1'b0, 8'h00);
    check("miso_after_deselect", 128'(MISO), 128'(0));
    $display("frame %0d word=%03h kind=%0d rdata=%02h wait=%0d timeout=%0d", frame_no, word, kind, rdata, w, timed_out);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_miso", 128'(MISO), 128'(0));
    check("reset_rx_valid", 128'(rx_valid), 128'(0));
    check("reset_rx_data", 128'(rx_data), 128'(0));
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 8'h00);

    // Directed: write, read address, read data, aborts
    run_frame(10'h03A, 10, 8'h5A, 1);
    run_frame(10'h23A, 10, 8'h00, 1);
    run_frame(10'h300, 10, 8'hA5, 1);
    run_frame(10'h2C4, 6, 8'h00, 1);
    run_frame(10'h0FF, 10, 8'h00, 1);
    run_frame(10'h3FF, 9, 8'h00, 1);
    run_frame(10'h3FF, 0, 8'h00, 1);
    run_frame(10'h211, 10, 8'h00, 2);
    run_frame(10'h0C3, 10, 8'h33, 1);
    run_frame(10'h3C3, 10, 8'h81, 3);

    // Wait-phase bound: just inside, at and well past the timeout
    for (int t = 0; t < 3; t++) begin
      int wv;
      wv = (t == 0) ? TX_TIMEOUT - 1 : (t == 1) ? TX_TIMEOUT : 100;
      if (seen_model) run_frame(10'h2AA, 10, 8'h00, 1);
      run_frame(10'h255, 10, 8'h00, 1);
      run_frame(10'h3E7, 10, 8'hC9, wv);
    end

    // Reset in the middle of MISO serialisation
    if (seen_model) run_frame(10'h201, 10, 8'h00, 1);
    run_frame(10'h2F0, 10, 8'h00, 1);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 9; i >= 0; i--) cycle(1'b0, 1'(i >= 8), 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b1, 8'hA5);
    check("pre_reset_miso", 128'(MISO), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_miso", 128'(MISO), 128'(0));
    check("async_reset_rx_valid", 128'(rx_valid), 128'(0));
    check("async_reset_rx_data", 128'(rx_data), 128'(0));
    seen_model = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    run_frame(10'h3C3, 10, 8'hFF, 1);
    run_frame(10'h381, 10, 8'hA5, 1);

    // Random frames
    for (int n = 0; n < 40; n++) begin
      int nb;
      nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : 10;
      run_frame(10'($urandom), nb, 8'($urandom), int'($urandom_range(1, 4)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_slave_if.md
# spi_slave_if

Serial front end of the SPI slave that feeds the single-port RAM: it deserialises MOSI into 10-bit command words, pulses `rx_valid` to the RAM, and serialises the RAM's 8-bit read data back out on MISO after `tx_valid`. It sits between the external SPI pins and the RAM inside the SPI wrapper. `clk` is the SPI serial clock, and all activity is on its rising edge.

## Interface
- `ADDR_SIZE`, 8: width of `tx_data`, and the number of MISO bits per read-data frame.
- `TX_TIMEOUT`, 16: maximum `clk` edges spent waiting for `tx_valid` (used only with the timeout feature).

Ports:
- `clk`  in  1  serial clock, rising-edge active.
- `rst_n`  in  1  asynchronous, active-low reset.
- `SS_n`  in  1  slave select, active low.
- `MOSI`  in  1  serial data in, MSB first.
- `MISO`  out  1  serial data out, MSB first.
- `rx_data`  out  10  assembled word: bits [9:8] are the command, bits [7:0] are the address or data.
- `rx_valid`  out  1  one-cycle pulse; `rx_data` is stable while it is high.
- `tx_data`  in  ADDR_SIZE  read data from the RAM.
- `tx_valid`  in  1  `tx_data` is valid.

## Operation
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- An internal flag `rd_addr_seen` records that a read address has been sent and the next read frame is a data fetch.
- IDLE:
  - On an edge with `SS_n`=0, go to CHK_CMD.
  - MOSI is ignored on that edge.
- CHK_CMD: the edge samples MOSI as `rx_data[9]` and selects the next state.
  - MOSI=0 → WRITE.
  - MOSI=1 and `rd_addr_seen`=0 → READ_ADD.
  - MOSI=1 and `rd_addr_seen`=1 → READ_DATA.
- WRITE, READ_ADD, READ_DATA: the next 9 edges shift in `rx_data[8:0]`, MSB first.
  - On the edge that samples bit 0, `rx_valid` goes high for exactly one cycle with the full word.
- On completion of a READ_ADD frame, set `rd_addr_seen`. On completion of a READ_DATA frame, clear it. WRITE frames leave it unchanged.
- READ_DATA, after `rx_valid`: wait for `tx_valid`=1.
  - On the edge that sees it, latch `tx_data` and drive `MISO <= tx_data[7]`.
  - The next 7 edges drive bits 6..0.
  - The edge after that drives MISO to 0 and holds it there.
- The FSM returns to IDLE only when an edge sees `SS_n`=1. Extra MOSI bits after a completed frame are ignored.
- SS_n abort: `SS_n`=1 on any edge in a non-IDLE state forces IDLE.
  - Clears the bit counter and MISO.
  - No `rx_valid` for an incomplete frame; `rd_addr_seen` is retained.
  - `SS_n`=1 on the same edge as the 10th bit: the abort wins and there is no `rx_valid`.

## Timing
- Reset values: IDLE state, `MISO`=0, `rx_valid`=0, `rx_data`=0, `rd_addr_seen`=0, counters 0.
- Reset mid-frame aborts immediately.
- A frame is 1 select edge + 10 data edges. `rx_valid` is visible in the cycle after the edge that samples the 10th bit.
- The RAM answers one edge after `rx_valid`. The slave latches `tx_data` on the following edge.
- The first MISO bit is valid 2 edges after `rx_valid` rises. The last bit is 7 edges after that.
- `rx_data` holds its value between frames. MISO changes only on rising edges.

## Configuration
- Macro: `SPI_SLAVE_TX_TIMEOUT_EN`.
- Defined:
  - In the READ_DATA wait phase, a counter increments each edge while `tx_valid`=0.
  - When it reaches `TX_TIMEOUT`, the FSM goes to IDLE, MISO stays 0 and the counter clears.
  - `rd_addr_seen` is already cleared.
  - `SS_n` is ignored until it rises and falls again.
- Undefined: the wait is unbounded and ends only on `tx_valid`, `SS_n`=1 or reset.

## Test plan
- Write frame: `SS_n`=0, MOSI 0,0,0x3A (10 bits), `SS_n`=1 → one `rx_valid` pulse with `rx_data`=10'h03A; `rd_addr_seen` stays 0.
- Read address, then read data:
  - Send 10'h23A → `rx_valid` with 10'h23A, `rd_addr_seen`=1.
  - Send 10'h300, with `tx_valid` and `tx_data`=8'hA5 one edge after `rx_valid` → MISO emits 1,0,1,0,0,1,0,1 on edges 2–9 after `rx_valid`, then 0; `rd_addr_seen`=0.
- Abort: `SS_n` rises after 6 data bits → no `rx_valid`, state IDLE. The next full frame of 10'h0FF is received correctly.
- Reset mid-READ_DATA serialisation: `rst_n` falls → MISO=0 and `rx_valid`=0 immediately. After release, a read frame selects READ_ADD, because `rd_addr_seen` was cleared.
- Timeout (macro defined, `TX_TIMEOUT`=16): hold `tx_valid`=0 after a READ_DATA `rx_valid` → IDLE on the 16th wait edge, MISO remains 0. Without the macro, the FSM is still in READ_DATA after 100 edges.
